// File: rtl/mole_launch_scheduler.sv
// Round sequencer for the mole datapath: round setup pulses, paced pseudo-random go pulses
// capped by the active-mole count, round timer and drain. Optional macro: MOLE_SCHED_SPEEDUP_EN.
module mole_launch_scheduler #(
   parameter int unsigned NUM_MOLES     = 8,
   parameter int unsigned MAX_ACTIVE    = 3,
   parameter int unsigned GAME_TICKS    = 60,
   parameter int unsigned INTERVAL_INIT = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 tick,
   input  logic [15:0]          seed,
   input  logic [NUM_MOLES-1:0] hiding,
   output logic [NUM_MOLES-1:0] control,
   output logic                 reset_moles,
   output logic                 reset_scores,
   output logic                 game_active,
   output logic                 game_over,
   output logic [7:0]           ticks_left,
   output logic [7:0]           launches
);

   localparam int unsigned IDX_W       = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;
   localparam logic [15:0] LFSR_INIT   = 16'hACE1;
   localparam logic [15:0] LFSR_MASK   = 16'hB400;
   localparam logic [3:0]  RELOAD_INIT = 4'(INTERVAL_INIT);

   typedef enum logic [2:0] {StIdle, StInit, StRun, StDrain, StDone} state_e;

   state_e               state_q;
   logic [15:0]          lfsr_q;
   logic [15:0]          lfsr_step;
   logic [NUM_MOLES-1:0] pending_q;
   logic [NUM_MOLES-1:0] eligible;
   logic [NUM_MOLES-1:0] sel;
   logic [3:0]           ivl_q;
   logic [3:0]           reload;
   logic                 found;
   logic                 enter_init;
   logic                 attempt;
   logic                 launch_fire;
   int unsigned          active_cnt;
   int unsigned          cand;
   int unsigned          j;

   assign lfsr_step   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
   assign eligible    = hiding & ~pending_q;
   assign enter_init  = ((state_q == StIdle) || (state_q == StDone)) && start;
   // The tick that exhausts the round never attempts a launch.
   assign attempt     = (state_q == StRun) && tick && (ticks_left > 8'd1) && (ivl_q == 4'd0);
   assign launch_fire = attempt && found && (active_cnt < MAX_ACTIVE);

   always_comb begin
      j          = 0;
      found      = 1'b0;
      sel        = '0;
      active_cnt = $countones(~hiding | pending_q);
      cand       = 32'(lfsr_q[IDX_W-1:0]) % NUM_MOLES;
      for (int unsigned k = 0; k < NUM_MOLES; k++) begin
         j = (cand + k) % NUM_MOLES;
         if (!found && eligible[j]) begin
            found  = 1'b1;
            sel[j] = 1'b1;
         end
      end
   end

`ifdef MOLE_SCHED_SPEEDUP_EN
   logic [3:0] reload_q;
   logic [2:0] burst_q;

   // Every eighth successful launch shortens the interval by one tick, down to one.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         reload_q <= RELOAD_INIT;
         burst_q  <= '0;
      end else if (enter_init) begin
         reload_q <= RELOAD_INIT;
         burst_q  <= '0;
      end else if (launch_fire) begin
         burst_q <= burst_q + 3'd1;
         if ((burst_q == 3'd7) && (reload_q > 4'd1)) begin
            reload_q <= reload_q - 4'd1;
         end
      end
   end

   assign reload = reload_q;
`else
   assign reload = RELOAD_INIT;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         lfsr_q       <= LFSR_INIT;
         pending_q    <= '0;
         ivl_q        <= '0;
         control      <= '0;
         reset_moles  <= 1'b0;
         reset_scores <= 1'b0;
         game_active  <= 1'b0;
         game_over    <= 1'b0;
         ticks_left   <= '0;
         launches     <= '0;
      end else begin
         control      <= '0;
         reset_moles  <= 1'b0;
         reset_scores <= 1'b0;
         // A mole that has left hiding no longer needs launch protection.
         pending_q    <= pending_q & hiding;
         if ((state_q == StRun) || (state_q == StDrain)) begin
            lfsr_q <= lfsr_step;
         end
         unique case (state_q)
            StIdle, StDone: begin
               if (enter_init) begin
                  state_q      <= StInit;
                  reset_moles  <= 1'b1;
                  reset_scores <= 1'b1;
                  game_over    <= 1'b0;
                  lfsr_q       <= (seed == 16'h0000) ? LFSR_INIT : seed;
                  ticks_left   <= 8'(GAME_TICKS);
                  launches     <= '0;
                  pending_q    <= '0;
                  ivl_q        <= RELOAD_INIT - 4'd1;
               end
            end
            StInit: begin
               state_q     <= StRun;
               game_active <= 1'b1;
            end
            StRun: begin
               if (tick) begin
                  if (ticks_left <= 8'd1) begin
                     ticks_left  <= '0;
                     game_active <= 1'b0;
                     state_q     <= StDrain;
                  end else begin
                     ticks_left <= ticks_left - 8'd1;
                     if (ivl_q == 4'd0) begin
                        ivl_q <= reload - 4'd1;
                     end else begin
                        ivl_q <= ivl_q - 4'd1;
                     end
                     if (launch_fire) begin
                        control   <= sel;
                        pending_q <= (pending_q & hiding) | sel;
                        if (launches != 8'hFF) begin
                           launches <= launches + 8'd1;
                        end
                     end
                  end
               end
            end
            StDrain: begin
               if ((hiding == '1) && (pending_q == '0)) begin
                  state_q   <= StDone;
                  game_over <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mole_launch_scheduler.sv
// Scoreboard bench for mole_launch_scheduler: expected go pulses are queued at the tick that
// causes them and a negedge monitor pops and compares every pulse the DUT presents.
module tb_mole_launch_scheduler;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start;
   logic       tick;
   logic [15:0] seed;
   logic [7:0] hiding;
   logic [7:0] control;
   logic       reset_moles;
   logic       reset_scores;
   logic       game_active;
   logic       game_over;
   logic [7:0] ticks_left;
   logic [7:0] launches;

   mole_launch_scheduler #(
      .NUM_MOLES    (8),
      .MAX_ACTIVE   (3),
      .GAME_TICKS   (60),
      .INTERVAL_INIT(2)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .tick        (tick),
      .seed        (seed),
      .hiding      (hiding),
      .control     (control),
      .reset_moles (reset_moles),
      .reset_scores(reset_scores),
      .game_active (game_active),
      .game_over   (game_over),
      .ticks_left  (ticks_left),
      .launches    (launches)
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   logic [7:0]  seen_ctl = 8'h00;

   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int unsigned at;
      logic [7:0]  ctl;
      logic [7:0]  cnt;
   } exp_t;

   exp_t exp_q[$];

   logic [15:0] m_lfsr;
   logic [7:0]  m_pend;
   logic [7:0]  m_launch;
   int          m_ticks;
   int          m_ivl;
   int          m_reload;
   int          m_burst;
   bit          m_run = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      logic [15:0] r;
      r = v >> 1;
      if (v[0]) r = r ^ 16'hB400;
      return r;
   endfunction

   // Predicts what the coming posedge does, given the inputs currently driven.
   task automatic model_edge();
      logic [7:0] elig;
      logic [7:0] pick;
      int         act;
      int         c;
      int         idx;
      if (!m_run) return;
      pick = 8'h00;
      if (tick) begin
         if (m_ticks <= 1) begin
            m_ticks = 0;
            m_run   = 1'b0;
         end else begin
            m_ticks = m_ticks - 1;
            if (m_ivl == 0) begin
               m_ivl = m_reload - 1;
               elig  = hiding & ~m_pend;
               act   = $countones(~hiding | m_pend);
               c     = int'(m_lfsr[2:0]);
               for (int k = 0; k < 8; k++) begin
                  idx = (c + k) % 8;
                  if (pick == 8'h00 && elig[idx]) pick[idx] = 1'b1;
               end
               if (act >= 3) pick = 8'h00;
               if (pick != 8'h00) begin
                  m_launch = (m_launch == 8'hFF) ? 8'hFF : m_launch + 8'd1;
`ifdef MOLE_SCHED_SPEEDUP_EN
                  m_burst++;
                  if (m_burst == 8) begin
                     m_burst = 0;
                     if (m_reload > 1) m_reload--;
                  end
`endif
                  exp_q.push_back('{cyc + 1, pick, m_launch});
               end
            end else begin
               m_ivl = m_ivl - 1;
            end
         end
      end
      m_pend = (m_pend & hiding) | pick;
      m_lfsr = lfsr_next(m_lfsr);
   endtask

   task automatic clk1();
      model_edge();
      @(negedge clock);
   endtask

   task automatic tk();
      tick = 1'b1;
      clk1();
      tick = 1'b0;
   endtask

   task automatic begin_round(input logic [15:0] s);
      seed     = s;
      start    = 1'b1;
      m_lfsr   = (s == 16'h0000) ? 16'hACE1 : s;
      m_pend   = 8'h00;
      m_ticks  = 60;
      m_launch = 8'h00;
      m_ivl    = 1;
      m_reload = 2;
      m_burst  = 0;
      m_run    = 1'b0;
      @(negedge clock);
      start = 1'b0;
      chk("init reset_moles", reset_moles, 1);
      chk("init reset_scores", reset_scores, 1);
      chk("init ticks_left", ticks_left, 60);
      chk("init launches", launches, 0);
      chk("init game_over", game_over, 0);
      @(negedge clock);
      chk("run reset_moles low", reset_moles, 0);
      chk("run reset_scores low", reset_scores, 0);
      chk("run game_active", game_active, 1);
      m_run = 1'b1;
   endtask

   always @(negedge clock) begin
      if (control !== 8'h00) begin
         seen_ctl = control;
         if (exp_q.size() == 0) begin
            chk("unexpected control pulse", control, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("control value", control, e.ctl);
            chk("launches at pulse", launches, e.cnt);
            chk("pulse cycle", cyc, e.at);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      int unsigned n0;
      bit          hit;
      reset  = 1'b1;
      start  = 1'b0;
      tick   = 1'b0;
      seed   = 16'h0000;
      hiding = 8'hFF;
      repeat (2) @(negedge clock);
      chk("reset control", control, 0);
      chk("reset game_active", game_active, 0);
      chk("reset game_over", game_over, 0);
      chk("reset ticks_left", ticks_left, 0);
      chk("reset launches", launches, 0);
      chk("reset reset_moles", reset_moles, 0);
      reset = 1'b0;
      @(negedge clock);
      chk("idle without start", game_active, 0);

      // Round 1: zero seed maps to ACE1, first attempt on the second tick picks mole 0.
      begin_round(16'h0000);
      tk();
      tk();
      clk1();
      chk("first launch index", seen_ctl, 8'h01);
      chk("first launch count", launches, 1);
      repeat (6) tk();
      chk("launches capped at three", launches, 3);
      hiding = 8'h00;
      clk1();
      hiding = 8'hF8;
      repeat (10) tk();
      chk("no launch with three out", launches, 3);
      chk("ticks_left after 18", ticks_left, 42);
      hiding = 8'h00;
      clk1();
      hiding = 8'hFF;
      n = 0;
      while (m_run && n < 80) begin
         tk();
         n++;
         if (m_run && (n % 4) == 0) begin
            hiding = 8'h00;
            clk1();
            hiding = 8'hFF;
         end
      end
      chk("ticks to end of round", n, 42);
      chk("drain game_active", game_active, 0);
      chk("drain ticks_left", ticks_left, 0);
      hiding = 8'h00;
      clk1();
      hiding = 8'hFE;
      repeat (3) clk1();
      chk("drain waits for hiding", game_over, 0);
      hiding = 8'hFF;
      clk1();
      chk("done game_over", game_over, 1);
      chk("done ticks_left", ticks_left, 0);
      chk("done launches hold", launches, m_launch);
      clk1();
      chk("done holds", game_over, 1);

      // Round 2 from DONE: moles return to hiding after every launch.
      begin_round(16'h1234);
      for (int i = 0; i < 20; i++) begin
         tk();
         hiding = 8'h00;
         clk1();
         hiding = 8'hFF;
         clk1();
      end
      chk("ticks_left after 20", ticks_left, 40);
`ifdef MOLE_SCHED_SPEEDUP_EN
      chk("launches with speedup", launches, 11);
`else
      chk("launches without speedup", launches, 10);
`endif
      chk("queue drained round 2", exp_q.size(), 0);

      // Asynchronous reset while a go pulse is being presented.
      hit = 1'b0;
      for (int i = 0; i < 4 && !hit; i++) begin
         n0   = exp_q.size();
         tick = 1'b1;
         model_edge();
         @(posedge clock);
         #2;
         if (exp_q.size() != n0) begin
            void'(exp_q.pop_back());
            chk("control high before reset", (control != 8'h00), 1);
            reset = 1'b1;
            #1;
            chk("mid reset control", control, 0);
            chk("mid reset game_active", game_active, 0);
            chk("mid reset game_over", game_over, 0);
            chk("mid reset ticks_left", ticks_left, 0);
            chk("mid reset launches", launches, 0);
            hit = 1'b1;
         end else begin
            @(negedge clock);
         end
         tick = 1'b0;
      end
      chk("reset test reached a pulse", hit, 1);
      m_run = 1'b0;
      tick  = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("queue empty after reset", exp_q.size(), 0);

      // Round 3 from IDLE repeats the zero-seed first launch.
      seen_ctl = 8'h00;
      begin_round(16'h0000);
      tk();
      tk();
      clk1();
      chk("restart first launch index", seen_ctl, 8'h01);
      chk("restart first launch count", launches, 1);
      clk1();
      chk("final queue empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
